alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one alu32 instance among NUM_REQ requesters, such as the execute stage, a branch-compare unit and a debug/test port.
- Selects one requester per cycle by round-robin and drives the shared ALU combinationally.
- Captures the ALU result into a per-requester response slot, which the requester holds until it consumes it.
- Sits between the requesters and the single ALU, so no datapath needs a private ALU copy.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- PTR_W, 1: round-robin pointer width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  request i presents an operation.
- req_a  input  32*NUM_REQ  operand a; requester i uses bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand b, same packing as req_a.
- req_op  input  4*NUM_REQ  ALUControl code; requester i uses bits [4i+3:4i].
- req_ready  output  NUM_REQ  combinational grant; a request transfers when req_valid[i] and req_ready[i] are both high.
- resp_valid  output  NUM_REQ  slot i holds a result.
- resp_result  output  32*NUM_REQ  registered result of slot i.
- resp_err  output  NUM_REQ  slot i result came from an undefined op (4'b1110 or 4'b1111).
- resp_ready  input  NUM_REQ  requester i consumes slot i this cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - rr_ptr cleared to 0.
  - All resp_valid, resp_err and resp_result cleared to 0.
  - While reset is high, req_ready is forced to 0 and no transfer occurs.
  - Reset asserted mid-operation discards any in-flight slot contents, with no partial result.
- Eligibility: eligible[i] = req_valid[i] && (!resp_valid[i] || resp_ready[i]).
  - A slot being drained this cycle can accept a new result in the same cycle (back-to-back issue).
- Arbitration: exactly one grant per cycle at most.
  - The grant goes to the first eligible index searched from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready is one-hot or zero.
- Pointer: on a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- ALU drive: the selected requester's a/b/op go to the shared alu32. With no grant the mux selects index 0; the result is ignored.
- Latency: a request granted in cycle T has resp_valid[g]=1 and resp_result[g]=ALU result from cycle T's operands at cycle T+1.
- Undefined op: resp_result is 32'h0 and resp_err is 1, never X. For defined ops resp_err is 0.
- Slot update, per slot, priority high to low:
  - reset;
  - grant to i: load the result and set valid;
  - resp_ready[i] && resp_valid[i]: clear valid;
  - otherwise hold.
- The slot's resp_result and resp_err stay stable while resp_valid=1 and resp_ready=0.
- resp_ready asserted while resp_valid=0 is ignored.
- A requester's operands may change freely when it is not granted; the arbiter samples them only in the grant cycle.
- There is no starvation: with all requesters continuously eligible, each is granted once every NUM_REQ cycles.

Decomposition:
- Shared package holds the ALU opcode constants:
  - ALU_ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100;
  - SLL=0101, SRL=0110, SRA=0111;
  - EQ=1000, LTU=1001, LT=1010, GEU=1011, GE=1100, JALR=1101;
  - ALU_OP_MAX=1101, used for the undefined-op check.
- The existing alu32 is instantiated once.
- Round-robin selection goes in a sub-module rr_pick, a pure combinational one-hot pick from (eligible, rr_ptr). It is reusable for other shared resources.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with req_valid=2'b11. Response: req_ready=0. After reset, resp_valid=0, resp_result=0 and rr_ptr=0.
- Single add: req0 with a=5, b=7, op=0000 in cycle T. Response: req_ready=2'b01 at T; resp_valid[0]=1 with result 12 at T+1. The slot holds with resp_ready=0 for 3 cycles, then clears the cycle after resp_ready=1.
- Contention: both requesters valid every cycle, resp_ready=1; req0 SUB(10,3), req1 SLT(-1,1). Response: grants alternate 01,10,01,10. Results are 7 and 1 respectively.
- Blocked slot: slot1 full with resp_ready[1]=0 and req1 valid. Response: req1 never granted and req0 granted every cycle. Asserting resp_ready[1] gives req1 a grant in that same cycle; the new result appears the next cycle with no bubble.
- Undefined op: req1 op=1111, a=1, b=1. Response: resp_result[1]=0, resp_err[1]=1. A following JALR(0x1003,0x4) gives 0x1006 with resp_err=0.
- Reset mid-flight: grant req0 at T and assert reset at T. Response: resp_valid[0]=0 at T+1 and the result is discarded.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcode constants and data types for the ALU-sharing arbiter and its ALU.
package alu_share_arbiter_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_EQ     = 4'b1000;
    localparam logic [3:0] ALU_LTU    = 4'b1001;
    localparam logic [3:0] ALU_LT     = 4'b1010;
    localparam logic [3:0] ALU_GEU    = 4'b1011;
    localparam logic [3:0] ALU_GE     = 4'b1100;
    localparam logic [3:0] ALU_JALR   = 4'b1101;
    localparam logic [3:0] ALU_OP_MAX = 4'b1101;

    // Codes above the last defined op produce a zero result flagged as an error.
    function automatic logic alu_op_undef(input logic [3:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle of the shared-ALU arbiter: request handshake plus per-requester response slots.
interface alu_share_arbiter_if
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [XLEN*NUM_REQ-1:0] req_a;
    logic [XLEN*NUM_REQ-1:0] req_b;
    logic [4*NUM_REQ-1:0]    req_op;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [XLEN*NUM_REQ-1:0] resp_result;
    logic [NUM_REQ-1:0]      resp_err;
    logic [NUM_REQ-1:0]      resp_ready;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/alu32.sv
// 32-bit combinational ALU; undefined op codes yield a zero result.
module alu32
    import alu_share_arbiter_pkg::*;
(
    input  word_t      a,
    input  word_t      b,
    input  logic [3:0] alu_control,
    output word_t      result
);
    word_t sum_s;

    assign sum_s = a + b;

    // Operation decode
    always_comb begin
        result = 32'h0000_0000;
        case (alu_control)
            ALU_ADD:  result = sum_s;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $signed(a) >>> b[4:0];
            ALU_EQ:   result = {31'd0, (a == b)};
            ALU_LTU:  result = {31'd0, (a < b)};
            ALU_LT:   result = {31'd0, ($signed(a) < $signed(b))};
            ALU_GEU:  result = {31'd0, (a >= b)};
            ALU_GE:   result = {31'd0, ($signed(a) >= $signed(b))};
            ALU_JALR: result = sum_s & 32'hFFFF_FFFE;
            default:  result = 32'h0000_0000;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first eligible index at or after ptr.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             found,
    output logic [PTR_W-1:0] idx
);
    int cand_s;

    // Search N positions starting at ptr, wrapping; the first hit wins
    always_comb begin
        grant  = {N{1'b0}};
        found  = 1'b0;
        idx    = {PTR_W{1'b0}};
        cand_s = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!found && eligible[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = PTR_W'(cand_s);
                found         = 1'b1;
            end else begin
                found = found;
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one alu32 among NUM_REQ requesters, each with a registered response slot.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus
);
    logic [NUM_REQ-1:0]      eligible_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic                    gnt_any_s;
    logic [PTR_W-1:0]        gnt_idx_s;
    logic [PTR_W-1:0]        rr_ptr_r;
    word_t                   sel_a_s;
    word_t                   sel_b_s;
    logic [3:0]              sel_op_s;
    word_t                   alu_y_s;
    logic                    sel_err_s;
    logic [NUM_REQ-1:0]      resp_valid_r;
    logic [NUM_REQ-1:0]      resp_err_r;
    logic [XLEN*NUM_REQ-1:0] resp_result_r;

    // A slot draining this cycle may take a new result; reset blocks all grants
    always_comb begin
        if (reset) begin
            eligible_s = {NUM_REQ{1'b0}};
        end else begin
            eligible_s = bus.req_valid & (~resp_valid_r | bus.resp_ready);
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .eligible (eligible_s),
        .ptr      (rr_ptr_r),
        .grant    (grant_s),
        .found    (gnt_any_s),
        .idx      (gnt_idx_s)
    );

    // Operand mux; falls back to requester 0 when idle (result unused)
    always_comb begin
        sel_a_s  = bus.req_a[XLEN-1:0];
        sel_b_s  = bus.req_b[XLEN-1:0];
        sel_op_s = bus.req_op[3:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_a_s  = bus.req_a[i*XLEN +: XLEN];
                sel_b_s  = bus.req_b[i*XLEN +: XLEN];
                sel_op_s = bus.req_op[i*4 +: 4];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    alu32 u_alu (
        .a           (sel_a_s),
        .b           (sel_b_s),
        .alu_control (sel_op_s),
        .result      (alu_y_s)
    );

    assign sel_err_s = alu_op_undef(sel_op_s);

    // Pointer moves just past the granted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (gnt_any_s) begin
            rr_ptr_r <= (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : gnt_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Response slots: a new grant overrides a same-cycle drain
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r  <= {NUM_REQ{1'b0}};
            resp_err_r    <= {NUM_REQ{1'b0}};
            resp_result_r <= {(XLEN*NUM_REQ){1'b0}};
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i]) begin
                    resp_valid_r[i]                 <= 1'b1;
                    resp_err_r[i]                   <= sel_err_s;
                    resp_result_r[i*XLEN +: XLEN]   <= alu_y_s;
                end else if (bus.resp_ready[i] && resp_valid_r[i]) begin
                    resp_valid_r[i] <= 1'b0;
                end else begin
                    resp_valid_r[i] <= resp_valid_r[i];
                end
            end
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_err    = resp_err_r;
    assign bus.resp_result = resp_result_r;
endmodule
